// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX operand forwarding / load-use hazard logic.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package fwd_pkg;

  // Widest register address any instance may use; narrower addresses are zero-extended.
  localparam int FWD_AW_MAX = 8;

  // EX operand mux select encoding; 5-7 are never produced.
  localparam logic [2:0] FWD_RF   = 3'd0;
  localparam logic [2:0] FWD_MEM1 = 3'd1;
  localparam logic [2:0] FWD_WB1  = 3'd2;
  localparam logic [2:0] FWD_MEM2 = 3'd3;
  localparam logic [2:0] FWD_WB2  = 3'd4;

  // Shadow of one pipeline stage's destination information.
  typedef struct packed {
    logic                        valid;
    logic [1:0]                  wr_en;
    logic [1:0][FWD_AW_MAX-1:0]  wr_addr;
    logic                        is_load;
  } stage_rec_t;

  // True when a write port of a stage record produces the register an operand reads.
  function automatic logic fwd_match(input stage_rec_t           rec,
                                     input logic                 port,
                                     input logic [FWD_AW_MAX-1:0] addr,
                                     input logic                 used,
                                     input logic                 zero_reg);
    return rec.valid && rec.wr_en[port] && (rec.wr_addr[port] == addr) && used &&
           !(zero_reg && (addr == '0));
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding priority select against the EX and MEM stage records.
// Latency: combinational.
// Backpressure: none; the caller decides whether the select is registered or discarded.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              used_i,
  input  stage_rec_t        ex_rec_i,
  input  stage_rec_t        mem_rec_i,
  output logic [2:0]        sel_o,
  output logic              load_hit_o
);

  logic [FWD_AW_MAX-1:0] addr;
  logic                  zr;
  logic                  ex_w1, ex_w2, mem_w1, mem_w2;

  assign addr   = FWD_AW_MAX'(src_i);
  assign zr     = (ZERO_REG != 0);
  assign ex_w1  = fwd_match(ex_rec_i,  1'b0, addr, used_i, zr);
  assign ex_w2  = fwd_match(ex_rec_i,  1'b1, addr, used_i, zr);
  assign mem_w1 = fwd_match(mem_rec_i, 1'b0, addr, used_i, zr);
  assign mem_w2 = fwd_match(mem_rec_i, 1'b1, addr, used_i, zr);

  // Only write1 of a load is late; write2 (base update) is an ALU result.
  assign load_hit_o = ex_w1 && ex_rec_i.is_load;

  // Younger producer first, write1 before write2; stage names shift by one as
  // the consumer moves into EX.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_w1)       sel_o = FWD_MEM1;
    else if (ex_w2)  sel_o = FWD_MEM2;
    else if (mem_w1) sel_o = FWD_WB1;
    else if (mem_w2) sel_o = FWD_WB2;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select generator and load-use hazard detector beside the ID/EX register.
// Latency: fwd_sel registered (1 cycle after decode); stall combinational.
// Backpressure: stall holds decode/PC for exactly one cycle per load-use and injects a bubble.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 3,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [1:0]                id_wr_en,
  input  logic [2*REG_AW-1:0]       id_wr_addr,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic [NUM_SRC*3-1:0]      fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  // No WB shadow is kept: the register file is write-before-read, so a WB
  // producer always resolves to the register file and never affects a select.
  stage_rec_t               ex_q, ex_d, mem_q, id_rec;
  logic [NUM_SRC*3-1:0]     fwd_sel_q, fwd_sel_d, sel_next;
  logic [NUM_SRC-1:0]       load_hit;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic                     bubble;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_src_sel #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
    ) u_sel (
      .src_i      (id_src[k*REG_AW +: REG_AW]),
      .used_i     (id_src_used[k]),
      .ex_rec_i   (ex_q),
      .mem_rec_i  (mem_q),
      .sel_o      (sel_next[k*3 +: 3]),
      .load_hit_o (load_hit[k])
    );
  end

  // Records are cleared asynchronously, so stall drops as soon as reset asserts.
  assign stall  = id_valid && !flush && (|load_hit);
  assign bubble = flush || stall;

  // Decode fields packed into a stage record.
  always_comb begin
    id_rec            = '0;
    id_rec.valid      = id_valid;
    id_rec.wr_en      = id_wr_en;
    id_rec.wr_addr[0] = FWD_AW_MAX'(id_wr_addr[REG_AW-1:0]);
    id_rec.wr_addr[1] = FWD_AW_MAX'(id_wr_addr[2*REG_AW-1:REG_AW]);
    id_rec.is_load    = id_is_load;
  end

  // Next EX contents, selects and saturating stall count.
  always_comb begin
    ex_d        = id_rec;
    fwd_sel_d   = sel_next;
    stall_cnt_d = stall_cnt_q;
    if (bubble) begin
      ex_d      = '0;
      fwd_sel_d = '0;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline shadow registers advance every cycle; stalls only replace EX with a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel   = fwd_sel_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expected results queued at drive time, checked after the edge.
// Latency: each step drives at posedge+1, samples stall at negedge, fwd_sel/stall_cnt at next posedge+1.
// Backpressure: stall is expected per step; the bench re-drives a stalled instruction itself.
module tb_fwd_hazard_unit;

  localparam int AW = 4;
  localparam int NS = 3;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [NS*AW-1:0]  id_src;
  logic [NS-1:0]     id_src_used;
  logic [1:0]        id_wr_en;
  logic [2*AW-1:0]   id_wr_addr;
  logic              id_is_load;
  logic              flush;
  logic [NS*3-1:0]   fwd_sel;
  logic              stall;
  logic [CW-1:0]     stall_cnt;

  fwd_hazard_unit #(
    .REG_AW   (AW),
    .NUM_SRC  (NS),
    .ZERO_REG (1),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic [NS*3-1:0] sel;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int s0, input int s1, input int s2,
                       input logic [2:0] used, input logic [1:0] we,
                       input int wa1, input int wa2, input bit ld, input bit fl);
    id_valid    = v;
    id_src      = {AW'(s2), AW'(s1), AW'(s0)};
    id_src_used = used;
    id_wr_en    = we;
    id_wr_addr  = {AW'(wa2), AW'(wa1)};
    id_is_load  = ld;
    flush       = fl;
  endtask

  // One decode cycle: drive, queue the expectation, observe, pop and compare.
  task automatic step(input string tag, input bit v, input int s0, input int s1, input int s2,
                      input logic [2:0] used, input logic [1:0] we, input int wa1, input int wa2,
                      input bit ld, input bit fl, input bit e_stall,
                      input int e0, input int e1, input int e2, input int e_cnt);
    exp_t e;
    logic obs_stall;
    drive(v, s0, s1, s2, used, we, wa1, wa2, ld, fl);
    e.stall = e_stall;
    e.sel   = {3'(e2), 3'(e1), 3'(e0)};
    e.cnt   = CW'(e_cnt);
    sb.push_back(e);
    @(negedge clk);
    obs_stall = stall;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "/queue"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "/stall"}, 16'(obs_stall), 16'(e.stall));
      chk({tag, "/sel"},   16'(fwd_sel),   16'(e.sel));
      chk({tag, "/cnt"},   16'(stall_cnt), 16'(e.cnt));
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0);
    #2;
    chk("rst/stall", 16'(stall), 16'd0);
    chk("rst/sel",   16'(fwd_sel), 16'd0);
    chk("rst/cnt",   16'(stall_cnt), 16'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // No hazards: producers of r1, r2, r0 ahead of a reader of {15,14,12}.
    step("nohz_w1", 1, 0, 0, 0,   3'b000, 2'b01, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    step("nohz_w2", 1, 0, 0, 0,   3'b000, 2'b01, 2, 0, 0, 0,  0, 0, 0, 0, 0);
    step("nohz_w0", 1, 0, 0, 0,   3'b000, 2'b01, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("nohz_rd", 1, 12, 14, 15, 3'b111, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU RAW: back-to-back gives MEM write1, one gap gives WB write1.
    step("raw_wA",  1, 0, 0, 0,   3'b000, 2'b01, 14, 0, 0, 0, 0, 0, 0, 0, 0);
    step("raw_ex",  1, 14, 0, 0,  3'b001, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    step("raw_mem", 1, 14, 0, 0,  3'b001, 2'b00, 0, 0, 0, 0,  0, 2, 0, 0, 0);

    // Write2 path and priorities.
    step("w2_a",     1, 0, 0, 0,  3'b000, 2'b01, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    step("w2_b",     1, 0, 0, 0,  3'b000, 2'b10, 0, 12, 0, 0, 0, 0, 0, 0, 0);
    step("w2_young", 1, 0, 12, 0, 3'b010, 2'b00, 0, 0, 0, 0,  0, 0, 3, 0, 0);
    step("w12_a",    1, 0, 0, 0,  3'b000, 2'b11, 12, 12, 0, 0, 0, 0, 0, 0, 0);
    step("w12_prio", 1, 0, 12, 0, 3'b010, 2'b00, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    step("mem_w1",   1, 0, 0, 12, 3'b100, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2, 0);
    step("wb_only",  1, 12, 0, 0, 3'b001, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("w2_only",  1, 0, 0, 0,  3'b000, 2'b10, 0, 9, 0, 0,  0, 0, 0, 0, 0);
    step("fill",     1, 0, 0, 0,  3'b000, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("mem_w2",   1, 9, 0, 0,  3'b001, 2'b00, 0, 0, 0, 0,  0, 4, 0, 0, 0);

    // Load-use: one stall with bubble, then WB write1 select.
    step("ld",        1, 0, 0, 0,  3'b000, 2'b01, 15, 0, 1, 0, 0, 0, 0, 0, 0);
    step("lu_stall",  1, 0, 0, 15, 3'b100, 2'b00, 0, 0, 0, 0,  1, 0, 0, 0, 1);
    step("lu_resume", 1, 0, 0, 15, 3'b100, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2, 1);

    // Flush beats the hazard and leaves a bubble in EX.
    step("ld2",        1, 0, 0, 0,  3'b000, 2'b01, 15, 0, 1, 0, 0, 0, 0, 0, 1);
    step("lu_flush",   1, 0, 0, 15, 3'b100, 2'b00, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    step("post_flush", 1, 0, 0, 15, 3'b100, 2'b00, 0, 0, 0, 0,  0, 0, 0, 2, 1);

    // Invalid decode never stalls, even with a matching load in EX.
    step("ld3",     1, 0, 0, 0,  3'b000, 2'b01, 15, 0, 1, 0, 0, 0, 0, 0, 1);
    step("novalid", 0, 0, 0, 15, 3'b100, 2'b00, 0, 0, 0, 0,  0, 0, 0, 1, 1);

    // Hard-wired zero register: neither forwarding nor stalling on r0.
    step("w_r0",  1, 0, 0, 0, 3'b000, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rd_r0", 1, 0, 0, 0, 3'b001, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("ld_r0", 1, 0, 0, 0, 3'b000, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    step("lu_r0", 1, 0, 0, 0, 3'b001, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Twenty load-use stalls push the 4-bit counter into saturation.
    c = 1;
    for (int i = 0; i < 20; i++) begin
      step("sat_ld", 1, 0, 0, 0, 3'b000, 2'b01, 15, 0, 1, 0, 0, 0, 0, 0, c);
      c = (c < 15) ? c + 1 : 15;
      step("sat_stall", 1, 0, 0, 15, 3'b100, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, c);
    end

    // Reset in the middle of a stall with a non-zero select registered.
    step("rst_pre", 1, 0, 0, 0, 3'b000, 2'b01, 5, 0, 0, 0,  0, 0, 0, 0, 15);
    step("rst_ld",  1, 5, 0, 0, 3'b001, 2'b01, 15, 0, 1, 0, 0, 1, 0, 0, 15);
    drive(1, 0, 0, 15, 3'b100, 2'b00, 0, 0, 0, 0);
    #1;
    chk("midrst_pre/stall", 16'(stall), 16'd1);
    chk("midrst_pre/sel",   16'(fwd_sel), 16'h001);
    rst_n = 1'b0;
    #1;
    chk("midrst/stall", 16'(stall), 16'd0);
    chk("midrst/sel",   16'(fwd_sel), 16'd0);
    chk("midrst/cnt",   16'(stall_cnt), 16'd0);
    chk("queue_empty",  16'(sb.size()), 16'd0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational MUXA/MUXB/MUXC forwarding selector.
- Tracks destination tags internally through EX, MEM and WB shadow stages, one per pipeline stage.
- Registers per-operand forwarding selects into EX and detects load-use hazards, issuing a one-cycle stall plus bubble.
- Sits beside the decode/execute pipeline register. Drives the EX operand muxes and the decode stall/hold line.

Parameters:
- REG_AW, 4, register address width (2^REG_AW architectural registers).
- NUM_SRC, 3, source operands per instruction (OP1, OP2, r15-style third read).
- ZERO_REG, 0, if 1 then address 0 never matches (hard-wired zero register).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode-stage instruction valid.
- id_src  in  NUM_SRC*REG_AW  decode source addresses; operand k in bits [k*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-operand "reads register" flag.
- id_wr_en  in  2  write-port enables: bit0 = result/load data (write1), bit1 = second write (write2, e.g. base/r15).
- id_wr_addr  in  2*REG_AW  write1 address in [REG_AW-1:0], write2 address in upper field.
- id_is_load  in  1  write1 data is only available after MEM.
- flush  in  1  kill the decode instruction (branch resolved).
- fwd_sel  out  NUM_SRC*3  registered EX operand selects, 3 bits per operand.
- stall  out  1  combinational; decode must hold, PC must hold.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding, fixed:
  - 0 = register file
  - 1 = MEM write1
  - 2 = WB write1
  - 3 = MEM write2
  - 4 = WB write2
  - 5–7 unused, never driven.
- Stage records ex_r, mem_r, wb_r each hold valid, wr_en[1:0], wr_addr[1:0], is_load.
- Reset (async): all records invalid, fwd_sel = 0, stall_cnt = 0. stall reads 0 while in reset.
- match(stage, port, k): all of the following must hold:
  - stage valid and stage.wr_en[port];
  - stage.wr_addr[port] == id_src[k];
  - id_src_used[k];
  - not (ZERO_REG and id_src[k] == 0).
- stall = id_valid & !flush & OR over k of match(ex_r, port 0, k) where ex_r.is_load.
  - A load's write2 is not load-dependent; it never causes a stall.
- Next select for operand k, highest priority first:
  1. match(ex_r, 0) -> 1
  2. match(ex_r, 1) -> 3
  3. match(mem_r, 0) -> 2
  4. match(mem_r, 1) -> 4
  5. otherwise 0.
  - The EX-stage producer reaches MEM and the MEM-stage producer reaches WB as this instruction enters EX, hence the mapping.
  - Younger producer wins. Within a stage, write1 beats write2.
- A wb_r match yields 0: the register file is write-before-read, so the data is already in it.
- Every rising edge (no stall, no flush):
  - ex_r <= decode fields, with valid = id_valid;
  - mem_r <= ex_r; wb_r <= mem_r;
  - fwd_sel <= next selects.
- Stall edge:
  - ex_r <= bubble (valid 0), fwd_sel <= 0;
  - mem_r/wb_r advance;
  - stall_cnt += 1, saturating at all-ones.
  - On the following cycle the load is in MEM; the matching select resolves to 2 and stall drops. Latency is exactly one stall cycle per load-use.
- Flush edge: same as a bubble (ex_r invalid, fwd_sel 0), no stall counted. Flush and hazard together: flush wins, stall = 0.
- id_valid = 0: a bubble enters EX. No stall is possible.
- Reset asserted mid-stall: stall falls immediately (records cleared asynchronously).

Decomposition:
- Package fwd_pkg holds:
  - select constants FWD_RF, FWD_MEM1, FWD_WB1, FWD_MEM2, FWD_WB2;
  - the stage-record struct (valid, wr_en, wr_addr, is_load).
- One sub-module, fwd_src_sel: per-operand priority match against ex_r/mem_r, returning a 3-bit select and a load-hit flag. Instantiate it NUM_SRC times under generate.

Test Plan:
- No hazards: ex/mem/wb write 0,2,1 while id_src = {15,14,12} -> fwd_sel all 0 next edge, stall 0.
- ALU RAW: instruction A writes r14 (write1). Next instruction reads OP1 = 14 -> EX operand0 sel = 1. Once A reaches MEM and the reader follows one cycle later -> sel = 2.
- Write2 path and priority:
  - ex_r write2 = r12 and mem_r write1 = r12, OP2 = 12 -> sel = 3 (younger wins).
  - ex_r write1 = r12 and write2 = r12 -> sel = 1.
- Load-use: load writes r15 (write1, is_load). Next instruction reads operand2 = 15 -> stall = 1 for exactly one cycle, EX receives a bubble with sel 0. The next edge gives sel = 2, and stall_cnt increments by 1.
- Flush during hazard: load-use condition with flush = 1 -> stall 0, ex_r invalid, stall_cnt unchanged.
- ZERO_REG = 1: producer writes r0, consumer reads r0 -> sel 0, no stall. Separately, force 2^CNT_W stalls (or preload CNT_W = 4 and run 20 stalls) -> stall_cnt holds at 15.
- Reset asserted mid-stall -> stall and fwd_sel go to 0 asynchronously.
